// File: rtl/tx_fifo_wr_ctrl_if.sv
// rtl/tx_fifo_wr_ctrl_if.sv - upstream byte-packet handshake into the TX FIFO write controller
interface tx_fifo_wr_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       pkt_end;
    logic       pkt_abort;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        output pkt_end,
        output pkt_abort,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  pkt_end,
        input  pkt_abort,
        output wr_ready
    );
endinterface

// File: rtl/tx_fifo_wr_ctrl.sv
// rtl/tx_fifo_wr_ctrl.sv - TX async FIFO write side with speculative pointer and packet commit
// Bytes land in RAM through spec_ptr; only whole packets advance the Gray w_count seen by the reader.
module tx_fifo_wr_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int AF_THRESH = 120
) (
    input  logic                w_clk,
    input  logic                rst,
    tx_fifo_wr_ctrl_if.slave    up,
    input  logic [ADDR_W:0]     r_count_sync,
    output logic [ADDR_W:0]     w_count,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [7:0]          mem_wdata,
    output logic                full,
    output logic                almost_full,
    output logic [ADDR_W:0]     used,
    output logic                overflow_err
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0] spec_ptr_q, spec_ptr_d;
    logic [PW-1:0] com_ptr_q,  com_ptr_d;
    logic [PW-1:0] w_count_q,  w_count_d;
    logic [1:0]    state_q,    state_d;
    logic          ovf_q,      ovf_d;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] occ_spec;
    logic [PW-1:0] spec_inc;
    logic          accept;
    logic          oversize;

    always_comb begin
        r_bin = '0;
        for (int i = 0; i < PW; i++) begin
            r_bin[i] = ^(r_count_sync >> i);
        end
    end

    assign occ_spec    = spec_ptr_q - r_bin;
    assign used        = com_ptr_q - r_bin;
    assign full        = (occ_spec == DEPTH);
    assign almost_full = (occ_spec >= AF_LVL);
    assign spec_inc    = spec_ptr_q + 1'b1;

    assign up.wr_ready = (state_q == ST_DROP) ? 1'b1 : (!full && !up.pkt_abort);
    assign accept      = up.wr_valid && up.wr_ready;

    // A full FIFO holding nothing but the open packet can never drain: drop the packet.
    assign oversize    = (state_q == ST_OPEN) && full && (com_ptr_q == r_bin);

    assign mem_we       = accept && (state_q != ST_DROP) && !up.pkt_abort;
    assign mem_waddr    = spec_ptr_q[ADDR_W-1:0];
    assign mem_wdata    = up.wr_data;
    assign w_count      = w_count_q;
    assign overflow_err = ovf_q;

    always_comb begin
        spec_ptr_d = spec_ptr_q;
        com_ptr_d  = com_ptr_q;
        w_count_d  = w_count_q;
        state_d    = state_q;
        ovf_d      = 1'b0;
        if (up.pkt_abort) begin
            spec_ptr_d = com_ptr_q;
            state_d    = ST_IDLE;
        end else if (oversize) begin
            spec_ptr_d = com_ptr_q;
            state_d    = ST_DROP;
            ovf_d      = 1'b1;
        end else if (accept) begin
            if (state_q == ST_DROP) begin
                if (up.pkt_end) begin
                    state_d = ST_IDLE;
                end
            end else begin
                spec_ptr_d = spec_inc;
                if (up.pkt_end) begin
                    com_ptr_d = spec_inc;
                    w_count_d = bin2gray(spec_inc);
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_OPEN;
                end
            end
        end
    end

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            spec_ptr_q <= '0;
            com_ptr_q  <= '0;
            w_count_q  <= '0;
            state_q    <= ST_IDLE;
            ovf_q      <= 1'b0;
        end else begin
            spec_ptr_q <= spec_ptr_d;
            com_ptr_q  <= com_ptr_d;
            w_count_q  <= w_count_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_tx_fifo_wr_ctrl.sv
// tb/tb_tx_fifo_wr_ctrl.sv - directed bench for tx_fifo_wr_ctrl with a RAM-write scoreboard
module tb_tx_fifo_wr_ctrl;
    logic       w_clk = 1'b0;
    logic       rst;
    logic [7:0] r_count_sync;
    logic [7:0] w_count;
    logic       mem_we;
    logic [6:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       full;
    logic       almost_full;
    logic [7:0] used;
    logic       overflow_err;

    tx_fifo_wr_ctrl_if bus ();

    tx_fifo_wr_ctrl #(.ADDR_W(7), .AF_THRESH(120)) dut (
        .w_clk        (w_clk),
        .rst          (rst),
        .up           (bus),
        .r_count_sync (r_count_sync),
        .w_count      (w_count),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .full         (full),
        .almost_full  (almost_full),
        .used         (used),
        .overflow_err (overflow_err)
    );

    always #5 w_clk = ~w_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [14:0] sb[$];
    logic [7:0]  m_spec, m_com, m_rd;

    function automatic logic [7:0] gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.pkt_end   = 1'b0;
        bus.pkt_abort = 1'b0;
        r_count_sync  = 8'h00;
        m_spec = 8'd0; m_com = 8'd0; m_rd = 8'd0;
        sb.delete();
        @(posedge w_clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_rd(input logic [7:0] b);
        r_count_sync = gray(b);
        m_rd         = b;
    endtask

    // One clock of stimulus; expected writes go into the scoreboard, RAM writes pop it.
    task automatic step(input logic v, input logic [7:0] d, input logic e, input logic a,
                        input logic exp_rdy, input logic exp_wr, input string tag);
        logic [7:0]  occ;
        logic [14:0] exp_w;
        bus.wr_valid  = v;
        bus.wr_data   = d;
        bus.pkt_end   = e;
        bus.pkt_abort = a;
        if (exp_wr) sb.push_back({m_spec[6:0], d});
        @(negedge w_clk);
        occ = m_spec - m_rd;
        chk({tag, "_ready"}, bus.wr_ready, exp_rdy);
        chk({tag, "_full"}, full, occ == 8'd128);
        chk({tag, "_afull"}, almost_full, occ >= 8'd120);
        chk({tag, "_used"}, used, m_com - m_rd);
        if (mem_we) begin
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                chk({tag, "_wr"}, {mem_waddr, mem_wdata}, exp_w);
            end else begin
                chk({tag, "_unexp_we"}, mem_we, 1'b0);
            end
        end
        chk({tag, "_sb_left"}, sb.size(), 0);
        @(posedge w_clk); #1;
        if (exp_wr) begin
            m_spec = m_spec + 8'd1;
            if (e) m_com = m_spec;
        end
        chk({tag, "_wcount"}, w_count, gray(m_com));
        bus.wr_valid  = 1'b0;
        bus.pkt_end   = 1'b0;
        bus.pkt_abort = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        rst = 1'b1;
        @(negedge w_clk);
        chk("rst_full", full, 1'b0);
        chk("rst_afull", almost_full, 1'b0);
        chk("rst_used", used, 8'd0);
        chk("rst_ready", bus.wr_ready, 1'b1);
        chk("rst_wcount", w_count, 8'd0);
        chk("rst_ovf", overflow_err, 1'b0);
        chk("rst_waddr", mem_waddr, 7'd0);
        @(posedge w_clk); #1;
        rst = 1'b0;

        // Basic 4-byte packet
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'hA1 + 8'(i), i == 3, 1'b0, 1'b1, 1'b1, "pkt4");
        chk("pkt4_wcount_gray4", w_count, 8'h06);
        chk("pkt4_used4", used, 8'd4);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "end_no_valid");

        // Abort mid-packet
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, "abort_pre");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, "abort");
        m_spec = m_com;
        chk("abort_wcount0", w_count, 8'd0);
        step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, "abort_post");
        step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, "abort_post");

        // Almost-full / full stall with committed data present
        do_reset();
        for (int i = 0; i < 100; i++)
            step(1'b1, 8'(i), i == 99, 1'b0, 1'b1, 1'b1, "p100");
        for (int i = 0; i < 28; i++)
            step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, "p2");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, "stall");
            chk("stall_no_ovf", overflow_err, 1'b0);
        end
        set_rd(8'd10);
        step(1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, "drain");
        chk("drain_used", used, 8'd119);

        // Oversize packet
        do_reset();
        for (int i = 0; i < 128; i++)
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, "big");
        step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, "big_full");
        m_spec = m_com;
        chk("big_ovf_pulse", overflow_err, 1'b1);
        step(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, "drop129");
        chk("big_ovf_one_cycle", overflow_err, 1'b0);
        step(1'b1, 8'h82, 1'b1, 1'b0, 1'b1, 1'b0, "drop130");
        chk("big_wcount0", w_count, 8'd0);
        chk("big_used0", used, 8'd0);
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b1, "after_drop");

        // Pointer wrap
        do_reset();
        for (int i = 0; i < 125; i++)
            step(1'b1, 8'(i), i == 124, 1'b0, 1'b1, 1'b1, "pre_a");
        set_rd(8'd125);
        for (int i = 0; i < 125; i++)
            step(1'b1, 8'(i), i == 124, 1'b0, 1'b1, 1'b1, "pre_b");
        set_rd(8'd250);
        for (int i = 0; i < 10; i++)
            step(1'b1, 8'hD0 + 8'(i), i == 9, 1'b0, 1'b1, 1'b1, "wrap");
        chk("wrap_wcount", w_count, 8'h06);
        chk("wrap_used", used, 8'd10);

        // Asynchronous reset mid-packet
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, "rstmid");
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h54;
        #2;
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        #1;
        chk("arst_waddr", mem_waddr, 7'd0);
        chk("arst_we", mem_we, 1'b0);
        chk("arst_wcount", w_count, 8'd0);
        chk("arst_used", used, 8'd0);
        chk("arst_full", full, 1'b0);
        chk("arst_ready", bus.wr_ready, 1'b1);
        @(posedge w_clk); #1;
        rst = 1'b0;
        m_spec = 8'd0; m_com = 8'd0; m_rd = 8'd0;
        step(1'b1, 8'h60, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
